radix6_stream_ctrl: RTL

Streaming sequencer for the radix-6 butterfly core. Accepts complex samples one per beat over a valid/ready handshake, gathers six into a frame, launches the frame into the free-running core, and tracks it through the core pipeline with a valid shift register. It then captures the six parallel results into a two-frame output buffer and streams them out serially with backpressure. Credit-based launch control guarantees that no core result is ever dropped, since the core itself cannot stall.

---
 rtl/radix6_stream_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/radix6_stream_ctrl.sv
// rtl/radix6_stream_ctrl.sv - radix-6 core streaming sequencer with credit-based launch and a two-frame output buffer
// Six input beats make one frame, a launch is gated by credits, and the captured core results are serialised out.
module radix6_stream_ctrl #(
  parameter int CORE_LAT = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_re,
  input  logic [DW-1:0] in_img,
  output logic [DW-1:0] core_a_re,
  output logic [DW-1:0] core_a_img,
  output logic [DW-1:0] core_b_re,
  output logic [DW-1:0] core_b_img,
  output logic [DW-1:0] core_c_re,
  output logic [DW-1:0] core_c_img,
  output logic [DW-1:0] core_d_re,
  output logic [DW-1:0] core_d_img,
  output logic [DW-1:0] core_e_re,
  output logic [DW-1:0] core_e_img,
  output logic [DW-1:0] core_f_re,
  output logic [DW-1:0] core_f_img,
  input  logic [DW-1:0] core_ao_re,
  input  logic [DW-1:0] core_ao_img,
  input  logic [DW-1:0] core_bo_re,
  input  logic [DW-1:0] core_bo_img,
  input  logic [DW-1:0] core_co_re,
  input  logic [DW-1:0] core_co_img,
  input  logic [DW-1:0] core_do_re,
  input  logic [DW-1:0] core_do_img,
  input  logic [DW-1:0] core_eo_re,
  input  logic [DW-1:0] core_eo_img,
  input  logic [DW-1:0] core_fo_re,
  input  logic [DW-1:0] core_fo_img,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_re,
  output logic [DW-1:0] out_img,
  output logic          out_last,
  output logic          busy
);

  typedef enum logic {FILL, FULL} state_t;

  state_t              state;
  logic [2:0]          in_cnt;
  logic [DW-1:0]       slot_re [6];
  logic [DW-1:0]       slot_im [6];
  logic [DW-1:0]       core_re [6];
  logic [DW-1:0]       core_im [6];
  logic [DW-1:0]       co_re   [6];
  logic [DW-1:0]       co_im   [6];
  logic [DW-1:0]       obuf_re [2][6];
  logic [DW-1:0]       obuf_im [2][6];
  logic [CORE_LAT-1:0] vpipe;
  logic                wr_ptr;
  logic                rd_ptr;
  logic [2:0]          out_idx;
  logic [1:0]          count;
  logic [1:0]          credits;

  logic accept;
  logic launch;
  logic capture;
  logic pop;
  logic ret;

  assign core_a_re  = core_re[0];
  assign core_a_img = core_im[0];
  assign core_b_re  = core_re[1];
  assign core_b_img = core_im[1];
  assign core_c_re  = core_re[2];
  assign core_c_img = core_im[2];
  assign core_d_re  = core_re[3];
  assign core_d_img = core_im[3];
  assign core_e_re  = core_re[4];
  assign core_e_img = core_im[4];
  assign core_f_re  = core_re[5];
  assign core_f_img = core_im[5];

  assign co_re[0] = core_ao_re;
  assign co_im[0] = core_ao_img;
  assign co_re[1] = core_bo_re;
  assign co_im[1] = core_bo_img;
  assign co_re[2] = core_co_re;
  assign co_im[2] = core_co_img;
  assign co_re[3] = core_do_re;
  assign co_im[3] = core_do_img;
  assign co_re[4] = core_eo_re;
  assign co_im[4] = core_eo_img;
  assign co_re[5] = core_fo_re;
  assign co_im[5] = core_fo_img;

  assign in_ready  = (state == FILL);
  assign accept    = in_valid && in_ready;
  assign launch    = (state == FULL) && (credits != 2'd0);
  assign capture   = vpipe[CORE_LAT-1];
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;
  assign ret       = pop && (out_idx == 3'd5);

  assign out_re   = out_valid ? obuf_re[rd_ptr][out_idx] : '0;
  assign out_img  = out_valid ? obuf_im[rd_ptr][out_idx] : '0;
  assign out_last = out_valid && (out_idx == 3'd5);
  assign busy     = (in_cnt != 3'd0) || (state == FULL) || (credits != 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FILL;
      in_cnt  <= '0;
      vpipe   <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      out_idx <= '0;
      count   <= '0;
      credits <= 2'd2;
      for (int i = 0; i < 6; i++) begin
        slot_re[i]    <= '0;
        slot_im[i]    <= '0;
        core_re[i]    <= '0;
        core_im[i]    <= '0;
        obuf_re[0][i] <= '0;
        obuf_im[0][i] <= '0;
        obuf_re[1][i] <= '0;
        obuf_im[1][i] <= '0;
      end
    end else begin
      if (accept) begin
        slot_re[in_cnt] <= in_re;
        slot_im[in_cnt] <= in_img;
        if (in_cnt == 3'd5) begin
          in_cnt <= '0;
          state  <= FULL;
        end else begin
          in_cnt <= in_cnt + 3'd1;
        end
      end

      if (launch) begin
        for (int i = 0; i < 6; i++) begin
          core_re[i] <= slot_re[i];
          core_im[i] <= slot_im[i];
        end
        state <= FILL;
      end

      // The core cannot stall, so the pipe only tracks where each launched frame is.
      vpipe[0] <= launch;
      for (int i = 1; i < CORE_LAT; i++) begin
        vpipe[i] <= vpipe[i-1];
      end

      if (capture) begin
        for (int i = 0; i < 6; i++) begin
          obuf_re[wr_ptr][i] <= co_re[i];
          obuf_im[wr_ptr][i] <= co_im[i];
        end
        wr_ptr <= ~wr_ptr;
      end

      if (pop) begin
        if (out_idx == 3'd5) begin
          out_idx <= '0;
          rd_ptr  <= ~rd_ptr;
        end else begin
          out_idx <= out_idx + 3'd1;
        end
      end

      case ({capture, ret})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase

      // Credits cover in-flight plus buffered frames, which bounds buffer occupancy at two.
      case ({launch, ret})
        2'b10:   credits <= credits - 2'd1;
        2'b01:   credits <= credits + 2'd1;
        default: credits <= credits;
      endcase
    end
  end

endmodule
